mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single main-memory port between three requesters: 0 = dcache/MEM-stage refill and
// writeback, 1 = icache refill, 2 = DTLB page-walk. Round-robin grant; one transaction in flight;
// memory has a fixed access latency. Sits between the caches/DTLB and the memory model and feeds
// read data back into the MEM-stage datapath ahead of the MEM/WB register.
// PARAMETERS
// MEM_LATENCY  5    memory access cycles per transaction (>=1)
// LINE_BITS    128  data width of one transfer
// PORTS
// clock        in   1             rising-edge clock
// reset        in   1             asynchronous, active-high
// req          in   3             per-requester request, held until its ready pulse
// req_we       in   3             per-requester write enable (1 = write)
// req_addr     in   3*32          per-requester address, requester i at [32*i +: 32]
// req_wdata    in   3*LINE_BITS   per-requester write data, requester i at [LINE_BITS*i +: LINE_BITS]
// grant        out  3             one-hot, 1-cycle pulse: request accepted
// ready        out  3             one-hot, 1-cycle pulse: transaction done, rdata valid
// rdata        out  LINE_BITS     read data of the last completed read
// mem_enable   out  1             memory access active
// mem_we       out  1             memory write
// mem_address  out  32            memory address
// mem_wdata    out  LINE_BITS     memory write data
// mem_rdata    in   LINE_BITS     memory read data, valid in the last BUSY cycle
// busy         out  1             arbiter not IDLE
// BEHAVIOUR
// - Reset (async) values: state=IDLE, grant=0, ready=0, rdata=0, mem_enable=0, mem_we=0,
//   mem_address=0, mem_wdata=0, busy=0, cnt=0, last_id=2 (requester 0 wins first).
// - States: IDLE -> BUSY -> DONE -> IDLE.
// - IDLE: if req!=0 at an edge, pick the winner scanning last_id+1, last_id+2, last_id+3 (mod 3).
//   Latch id, we, addr, wdata. Set last_id=id, cnt=MEM_LATENCY-1, state=BUSY.
//   grant[id]=1 for exactly the following cycle.
// - BUSY: mem_enable=1; mem_we/mem_address/mem_wdata hold the latched values. Each edge, cnt
//   decrements. The edge that sees cnt==0 captures rdata<=mem_rdata (reads only; a write leaves
//   rdata unchanged), clears mem_enable/mem_we, and sets state=DONE.
// - DONE: ready[id]=1 for this single cycle; no arbitration; next edge -> IDLE.
// - Latency: req sampled at edge E0 -> mem_enable high for cycles E0..E0+MEM_LATENCY ->
//   ready high in the cycle after edge E0+MEM_LATENCY. Back-to-back period is MEM_LATENCY+2 cycles.
// - Dropping req while BUSY does not abort: the transaction completes and ready still pulses.
//   Changes to req_addr/req_wdata after grant are ignored.
// - A requester still asserting req in its ready cycle is not re-granted in that cycle (DONE
//   does not arbitrate). If it holds req into IDLE, it is a new request.
// - Simultaneous requests: exactly one grant per transaction. Losers wait in round-robin order.
//   With all three held, grant order is 0,1,2,0,...
// - req bits for non-winners are ignored while not IDLE. grant and ready are never both high.
// - Reset mid-transaction: immediate return to reset values. No ready is issued for the aborted
//   access, and last_id returns to 2.
// - busy = (state != IDLE).
// TESTING
// - Single read, MEM_LATENCY=5: req=3'b001, addr0=0x100 at E0 -> grant=001 next cycle,
//   mem_address=0x100 for 5 cycles, ready=001 after E5, rdata=mem_rdata.
// - All req=3'b111 held -> grants 001,010,100,001 at periods of 7 cycles, never two-hot.
// - Write from req 2 (we=1, wdata=0xDEAD..) -> mem_we=1 with mem_wdata=0xDEAD.. for 5 cycles,
//   rdata unchanged, ready=100.
// - req0 held through its ready cycle with req1 also high -> next grant=010 (round-robin),
//   not 001.
// - req1 dropped 2 cycles after grant -> ready=010 still pulses after MEM_LATENCY;
//   no further grant.
// - reset asserted mid-BUSY -> all outputs 0 the same cycle, no ready. After release, req=3'b101
//   -> grant=001.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter that shares the single main-memory port between the
// dcache (0), icache (1) and DTLB page walker (2). One transaction is in
// flight at a time and the memory answers after a fixed number of cycles.
// All outputs are registered.

module mem_port_arbiter #(
  parameter int MEM_LATENCY = 5,
  parameter int LINE_BITS   = 128
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             req,
  input  logic [2:0]             req_we,
  input  logic [95:0]            req_addr,
  input  logic [3*LINE_BITS-1:0] req_wdata,
  output logic [2:0]             grant,
  output logic [2:0]             ready,
  output logic [LINE_BITS-1:0]   rdata,
  output logic                   mem_enable,
  output logic                   mem_we,
  output logic [31:0]            mem_address,
  output logic [LINE_BITS-1:0]   mem_wdata,
  input  logic [LINE_BITS-1:0]   mem_rdata,
  output logic                   busy
);

  // Counter only has to hold MEM_LATENCY-1; keep it at least one bit wide.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [1:0]             last_id_r;
  logic [2:0]             id_oh_r;

  logic [2:0]             pick_s;
  logic                   win_valid_s;
  logic [1:0]             win_id_s;
  logic [2:0]             win_oh_s;
  logic                   win_we_s;
  logic [31:0]            win_addr_s;
  logic [LINE_BITS-1:0]   win_wdata_s;

  // Round-robin pick: scan last+1, last+2, last+3 (mod 3).
  // Result bit 2 = some requester found, bits 1:0 = its index.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] res;
    res = 3'b000;
    case (last)
      2'd0: begin
        if (r[1])      res = {1'b1, 2'd1};
        else if (r[2]) res = {1'b1, 2'd2};
        else if (r[0]) res = {1'b1, 2'd0};
        else           res = 3'b000;
      end
      2'd1: begin
        if (r[2])      res = {1'b1, 2'd2};
        else if (r[0]) res = {1'b1, 2'd0};
        else if (r[1]) res = {1'b1, 2'd1};
        else           res = 3'b000;
      end
      default: begin
        if (r[0])      res = {1'b1, 2'd0};
        else if (r[1]) res = {1'b1, 2'd1};
        else if (r[2]) res = {1'b1, 2'd2};
        else           res = 3'b000;
      end
    endcase
    return res;
  endfunction

  // Select the winning requester and mux out its transaction fields.
  always_comb begin
    pick_s      = rr_pick(req, last_id_r);
    win_valid_s = pick_s[2];
    win_id_s    = pick_s[1:0];
    win_oh_s    = 3'b000;
    win_we_s    = 1'b0;
    win_addr_s  = 32'h0000_0000;
    win_wdata_s = '0;
    case (win_id_s)
      2'd0: begin
        win_oh_s    = 3'b001;
        win_we_s    = req_we[0];
        win_addr_s  = req_addr[31:0];
        win_wdata_s = req_wdata[LINE_BITS-1:0];
      end
      2'd1: begin
        win_oh_s    = 3'b010;
        win_we_s    = req_we[1];
        win_addr_s  = req_addr[63:32];
        win_wdata_s = req_wdata[2*LINE_BITS-1:LINE_BITS];
      end
      2'd2: begin
        win_oh_s    = 3'b100;
        win_we_s    = req_we[2];
        win_addr_s  = req_addr[95:64];
        win_wdata_s = req_wdata[3*LINE_BITS-1:2*LINE_BITS];
      end
      default: begin
        win_oh_s    = 3'b000;
        win_we_s    = 1'b0;
        win_addr_s  = 32'h0000_0000;
        win_wdata_s = '0;
      end
    endcase
  end

  // Arbitration FSM: IDLE grants, BUSY drives memory for MEM_LATENCY cycles,
  // DONE pulses ready for one cycle without arbitrating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      last_id_r   <= 2'd2;
      id_oh_r     <= 3'b000;
      grant       <= 3'b000;
      ready       <= 3'b000;
      rdata       <= '0;
      mem_enable  <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= 32'h0000_0000;
      mem_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      grant <= 3'b000;
      ready <= 3'b000;
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s) begin
            state_r     <= ST_BUSY;
            busy        <= 1'b1;
            grant       <= win_oh_s;
            id_oh_r     <= win_oh_s;
            last_id_r   <= win_id_s;
            cnt_r       <= CNT_LOAD;
            mem_enable  <= 1'b1;
            mem_we      <= win_we_s;
            mem_address <= win_addr_s;
            mem_wdata   <= win_wdata_s;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt_r == '0) begin
            // mem_we still holds the latched direction on this edge
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            mem_enable <= 1'b0;
            mem_we     <= 1'b0;
            ready      <= id_oh_r;
            state_r    <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          mem_enable <= 1'b0;
          mem_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MEM_LATENCY=5, LINE_BITS=128).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_mem_port_arbiter;

  localparam int LAT = 5;
  localparam int LB  = 128;

  logic            clock;
  logic            reset;
  logic [2:0]      req;
  logic [2:0]      req_we;
  logic [95:0]     req_addr;
  logic [3*LB-1:0] req_wdata;
  logic [2:0]      grant;
  logic [2:0]      ready;
  logic [LB-1:0]   rdata;
  logic            mem_enable;
  logic            mem_we;
  logic [31:0]     mem_address;
  logic [LB-1:0]   mem_wdata;
  logic [LB-1:0]   mem_rdata;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .LINE_BITS(LB)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .grant       (grant),
    .ready       (ready),
    .rdata       (rdata),
    .mem_enable  (mem_enable),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: read data is a fixed function of the address.
  function automatic logic [LB-1:0] rd_model(input logic [31:0] a);
    return {4{a ^ 32'hA5A5_0000}};
  endfunction

  assign mem_rdata = rd_model(mem_address);

  task automatic check_value(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, " grant"},       LB'(grant),       LB'(3'b000));
    check_value({tag, " ready"},       LB'(ready),       LB'(3'b000));
    check_value({tag, " rdata"},       rdata,            '0);
    check_value({tag, " mem_enable"},  LB'(mem_enable),  LB'(1'b0));
    check_value({tag, " mem_we"},      LB'(mem_we),      LB'(1'b0));
    check_value({tag, " mem_address"}, LB'(mem_address), LB'(32'h0));
    check_value({tag, " mem_wdata"},   mem_wdata,        '0);
    check_value({tag, " busy"},        LB'(busy),        LB'(1'b0));
  endtask

  // Wait (bounded) for a grant pulse and compare it.
  task automatic wait_grant(input logic [2:0] exp, output int waited);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (grant == 3'b000 && waited < 20);
    check_value("grant", LB'(grant), LB'(exp));
  endtask

  // One full transaction: grant, LAT cycles of memory access, ready pulse.
  // Returns on the falling edge of the ready cycle.
  task automatic expect_txn(input logic [2:0] exp_g, input logic [31:0] exp_addr,
                            input logic exp_we, input logic [LB-1:0] exp_wdata,
                            input logic [LB-1:0] exp_rdata, input int drop_at,
                            output int waited);
    wait_grant(exp_g, waited);
    check_value("mem_address", LB'(mem_address), LB'(exp_addr));
    check_value("mem_we",      LB'(mem_we),      LB'(exp_we));
    check_value("busy",        LB'(busy),        LB'(1'b1));
    if (exp_we) check_value("mem_wdata", mem_wdata, exp_wdata);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clock);
      if (k == drop_at) req = 3'b000;
      check_value("mem_enable hold", LB'(mem_enable), LB'(1'b1));
      check_value("ready early",     LB'(ready),      LB'(3'b000));
      check_value("grant stuck",     LB'(grant),      LB'(3'b000));
    end
    @(negedge clock);
    check_value("ready",          LB'(ready),      LB'(exp_g));
    check_value("mem_enable off", LB'(mem_enable), LB'(1'b0));
    check_value("grant in ready", LB'(grant),      LB'(3'b000));
    check_value("rdata",          rdata,           exp_rdata);
  endtask

  initial begin
    int w;
    logic [2:0] seen;
    logic [LB-1:0] dead;
    dead = {4{32'hDEAD_BEEF}};

    reset     = 1'b1;
    req       = 3'b000;
    req_we    = 3'b000;
    req_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    req_wdata = '0;

    // Reset state
    @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Single read from requester 0
    req = 3'b001;
    expect_txn(3'b001, 32'h100, 1'b0, '0, rd_model(32'h100), -1, w);
    req = 3'b000;
    @(negedge clock);
    check_value("busy after done", LB'(busy), LB'(1'b0));

    // All three held: 0,1,2,0 from a fresh reset, 7-cycle period
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req = 3'b111;
    expect_txn(3'b001, 32'h100, 1'b0, '0, rd_model(32'h100), -1, w);
    expect_txn(3'b010, 32'h200, 1'b0, '0, rd_model(32'h200), -1, w);
    check_value("rr gap 1", LB'(w), LB'(2));
    expect_txn(3'b100, 32'h300, 1'b0, '0, rd_model(32'h300), -1, w);
    check_value("rr gap 2", LB'(w), LB'(2));
    expect_txn(3'b001, 32'h100, 1'b0, '0, rd_model(32'h100), -1, w);
    check_value("rr gap 3", LB'(w), LB'(2));
    req = 3'b000;

    // Write from requester 2: rdata keeps the last read value
    req_we = 3'b100;
    req_wdata[3*LB-1:2*LB] = dead;
    req = 3'b100;
    expect_txn(3'b100, 32'h300, 1'b1, dead, rd_model(32'h100), -1, w);
    req = 3'b000;
    req_we = 3'b000;

    // req0 held through its ready cycle with req1 high: next grant goes to 1
    req = 3'b011;
    expect_txn(3'b001, 32'h100, 1'b0, '0, rd_model(32'h100), -1, w);
    expect_txn(3'b010, 32'h200, 1'b0, '0, rd_model(32'h200), -1, w);
    check_value("no regrant gap", LB'(w), LB'(2));
    req = 3'b000;

    // req1 dropped two cycles after grant: still completes, no further grant
    @(negedge clock);
    req = 3'b010;
    req_addr[63:32] = 32'h0000_0240;
    expect_txn(3'b010, 32'h240, 1'b0, '0, rd_model(32'h240), 2, w);
    seen = 3'b000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      seen = seen | grant | ready;
    end
    check_value("no grant after drop", LB'(seen), LB'(3'b000));

    // Reset mid-BUSY: outputs clear at once, no ready, last_id back to 2
    req = 3'b001;
    wait_grant(3'b001, w);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid reset");
    req = 3'b101;
    seen = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      seen = seen | ready | grant;
    end
    check_value("no ready in reset", LB'(seen), LB'(3'b000));
    reset = 1'b0;
    expect_txn(3'b001, 32'h100, 1'b0, '0, rd_model(32'h100), -1, w);
    req = 3'b000;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
